// File: rtl/lagarto_fp_mult_arbiter.sv
`default_nettype none
// =============================================================================
// lagarto_fp_mult_arbiter - round-robin sharing of one pipelined mantissa
// multiplier with tag-tracked response routing. Option: LAGARTO_FP_MULT_ARB_PRIO_EN
// Rev 1.0
// =============================================================================
module lagarto_fp_mult_arbiter #(
  parameter int MANTISSA = 53,
  parameter int NREQ     = 3,
  parameter int MUL_LAT  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     lock_i,
  input  logic [NREQ-1:0]          req_valid_i,
`ifdef LAGARTO_FP_MULT_ARB_PRIO_EN
  input  logic [NREQ-1:0]          req_prio_i,
`endif
  input  logic [NREQ*MANTISSA-1:0] req_src1_i,
  input  logic [NREQ*MANTISSA-1:0] req_src2_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     mul_valid_o,
  output logic [MANTISSA-1:0]      mul_src1_o,
  output logic [MANTISSA-1:0]      mul_src2_o,
  output logic                     mul_lock_o,
  output logic                     mul_flush_o,
  input  logic                     mul_result_valid_i,
  input  logic [2*MANTISSA-1:0]    mul_result_data_i,
  output logic [NREQ-1:0]          rsp_valid_o,
  output logic [2*MANTISSA-1:0]    rsp_data_o,
  output logic                     err_o
);

  localparam int             IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

  logic [NREQ-1:0]              cand;
  logic [NREQ-1:0]              grant;
  logic [IDW-1:0]               grant_idx;
  logic                         found;
  logic [IDW:0]                 scan;
  logic [IDW-1:0]               last_q, last_d;
  logic [MUL_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;
  logic                         err_q, err_d;
  logic                         tail_vld;
  logic [IDW-1:0]               tail_id;
  logic [NREQ-1:0]              rsp_valid;

  // Priority requesters, when any are valid, mask out the rest before the scan.
`ifdef LAGARTO_FP_MULT_ARB_PRIO_EN
  assign cand = (|(req_valid_i & req_prio_i)) ? (req_valid_i & req_prio_i) : req_valid_i;
`else
  assign cand = req_valid_i;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    if (!rst_i && !lock_i && !flush_i) begin
      for (int i = 1; i <= NREQ; i++) begin
        scan = {1'b0, last_q} + (IDW + 1)'(i);
        if (scan >= NREQ_W) begin
          scan = scan - NREQ_W;
        end
        if (!found && cand[scan[IDW-1:0]]) begin
          found                  = 1'b1;
          grant_idx              = scan[IDW-1:0];
          grant[scan[IDW-1:0]]   = 1'b1;
        end
      end
    end
  end

  assign last_d = found ? grant_idx : last_q;

  always_comb begin
    mul_src1_o = '0;
    mul_src2_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        mul_src1_o = req_src1_i[k*MANTISSA +: MANTISSA];
        mul_src2_o = req_src2_i[k*MANTISSA +: MANTISSA];
      end
    end
  end

  // Flush wins over lock so a stalled pipeline can still be emptied.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    if (flush_i) begin
      tag_vld_d = '0;
    end else if (!lock_i) begin
      tag_vld_d[0] = found;
      tag_id_d[0]  = grant_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld_d[s] = tag_vld_q[s-1];
        tag_id_d[s]  = tag_id_q[s-1];
      end
    end
  end

  assign tail_vld = tag_vld_q[MUL_LAT-1];
  assign tail_id  = tag_id_q[MUL_LAT-1];

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = !rst_i && tail_vld && mul_result_valid_i && (tail_id == IDW'(k));
    end
  end

  assign err_d = err_q | (!lock_i && !flush_i && (tail_vld != mul_result_valid_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= LAST_RST;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o = grant;
  assign mul_valid_o = found;
  assign mul_lock_o  = lock_i & ~rst_i;
  assign mul_flush_o = flush_i & ~rst_i;
  assign rsp_valid_o = rsp_valid;
  assign rsp_data_o  = (|rsp_valid) ? mul_result_data_i : '0;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lagarto_fp_mult_arbiter.sv
`default_nettype none
// =============================================================================
// tb_lagarto_fp_mult_arbiter - directed vector bench with a behavioural
// two-stage multiplier. Rev 1.0
// =============================================================================
module tb_lagarto_fp_mult_arbiter;

  localparam int M  = 53;
  localparam int N  = 3;
  localparam int L  = 2;
  localparam int NV = 37;
  localparam logic [23:0] DA = 24'h030201;
  localparam logic [23:0] DB = 24'h020202;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             lock = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*M-1:0]   req_src1 = '0;
  logic [N*M-1:0]   req_src2 = '0;
  logic [N-1:0]     ready;
  logic             mul_valid;
  logic [M-1:0]     mul_src1, mul_src2;
  logic             mul_lock, mul_flush;
  logic             res_valid;
  logic [2*M-1:0]   res_data;
  logic [N-1:0]     rsp_valid;
  logic [2*M-1:0]   rsp_data;
  logic             err;
  logic             force_vld = 1'b0;
`ifdef LAGARTO_FP_MULT_ARB_PRIO_EN
  logic [N-1:0]     prio = '0;
`endif

  always #5 clk = ~clk;

  lagarto_fp_mult_arbiter #(.MANTISSA(M), .NREQ(N), .MUL_LAT(L)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .lock_i             (lock),
    .req_valid_i        (req_valid),
`ifdef LAGARTO_FP_MULT_ARB_PRIO_EN
    .req_prio_i         (prio),
`endif
    .req_src1_i         (req_src1),
    .req_src2_i         (req_src2),
    .req_ready_o        (ready),
    .mul_valid_o        (mul_valid),
    .mul_src1_o         (mul_src1),
    .mul_src2_o         (mul_src2),
    .mul_lock_o         (mul_lock),
    .mul_flush_o        (mul_flush),
    .mul_result_valid_i (res_valid),
    .mul_result_data_i  (res_data),
    .rsp_valid_o        (rsp_valid),
    .rsp_data_o         (rsp_data),
    .err_o              (err)
  );

  // Multiplier stand-in: lock freezes it, flush empties it and kills its output.
  logic [L-1:0]          m_vld;
  logic [L-1:0][2*M-1:0] m_dat;
  logic [2*M-1:0]        prod;
  assign prod = {{M{1'b0}}, mul_src1} * {{M{1'b0}}, mul_src2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= '0;
      m_dat <= '0;
    end else if (mul_flush) begin
      m_vld <= '0;
    end else if (!mul_lock) begin
      m_vld <= {m_vld[0], mul_valid};
      m_dat <= {m_dat[0], prod};
    end
  end

  assign res_valid = force_vld | (m_vld[L-1] & ~mul_flush);
  assign res_data  = m_dat[L-1];

  typedef struct {
    logic [2:0]  v;
    logic        lk;
    logic        fl;
    logic [23:0] a;
    logic [23:0] b;
    logic [2:0]  rdy;
    logic [2:0]  rsp;
    logic [15:0] dat;
  } vec_t;

  vec_t tv [NV];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [2:0] v, input logic lk, input logic fl,
                              input logic [2:0] rdy, input logic [2:0] rsp,
                              input logic [15:0] dat);
    vec_t r;
    r.v = v; r.lk = lk; r.fl = fl; r.a = DA; r.b = DB;
    r.rdy = rdy; r.rsp = rsp; r.dat = dat;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic lk, input logic fl,
                       input logic [23:0] a, input logic [23:0] b);
    req_valid = v;
    lock      = lk;
    flush     = fl;
    for (int k = 0; k < N; k++) begin
      req_src1[k*M +: M] = M'(a[k*8 +: 8]);
      req_src2[k*M +: M] = M'(b[k*8 +: 8]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] es1, es2;

    tv[0]  = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[1]  = mk(3'b111, 0, 0, 3'b001, 3'b000, 16'd0);
    tv[2]  = mk(3'b111, 0, 0, 3'b010, 3'b000, 16'd0);
    tv[3]  = mk(3'b111, 0, 0, 3'b100, 3'b001, 16'd2);
    tv[4]  = mk(3'b111, 0, 0, 3'b001, 3'b010, 16'd4);
    tv[5]  = mk(3'b111, 0, 0, 3'b010, 3'b100, 16'd6);
    tv[6]  = mk(3'b111, 0, 0, 3'b100, 3'b001, 16'd2);
    tv[7]  = mk(3'b000, 0, 0, 3'b000, 3'b010, 16'd4);
    tv[8]  = mk(3'b000, 0, 0, 3'b000, 3'b100, 16'd6);
    tv[9]  = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[10] = mk(3'b010, 0, 0, 3'b010, 3'b000, 16'd0);
    tv[11] = mk(3'b010, 0, 0, 3'b010, 3'b000, 16'd0);
    tv[12] = mk(3'b010, 0, 0, 3'b010, 3'b010, 16'd4);
    tv[13] = mk(3'b000, 0, 0, 3'b000, 3'b010, 16'd4);
    tv[14] = mk(3'b000, 0, 0, 3'b000, 3'b010, 16'd4);
    tv[15] = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[16] = mk(3'b011, 0, 0, 3'b001, 3'b000, 16'd0);
    tv[17] = mk(3'b101, 0, 0, 3'b100, 3'b000, 16'd0);
    tv[18] = mk(3'b110, 0, 0, 3'b010, 3'b001, 16'd2);
    tv[19] = mk(3'b000, 0, 0, 3'b000, 3'b100, 16'd6);
    tv[20] = mk(3'b000, 0, 0, 3'b000, 3'b010, 16'd4);
    tv[21] = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[22] = mk(3'b001, 0, 0, 3'b001, 3'b000, 16'd0);
    tv[23] = mk(3'b100, 0, 0, 3'b100, 3'b000, 16'd0);
    tv[24] = mk(3'b111, 0, 1, 3'b000, 3'b000, 16'd0);
    tv[25] = mk(3'b111, 0, 0, 3'b001, 3'b000, 16'd0);
    tv[26] = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[27] = mk(3'b000, 0, 0, 3'b000, 3'b001, 16'd2);
    tv[28] = mk(3'b010, 0, 0, 3'b010, 3'b000, 16'd0);
    tv[28].a = 24'h030301;
    tv[28].b = 24'h020502;
    tv[29] = mk(3'b111, 1, 0, 3'b000, 3'b000, 16'd0);
    tv[30] = mk(3'b111, 1, 0, 3'b000, 3'b000, 16'd0);
    tv[31] = mk(3'b111, 1, 0, 3'b000, 3'b000, 16'd0);
    tv[32] = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[33] = mk(3'b000, 0, 0, 3'b000, 3'b010, 16'h000F);
    tv[34] = mk(3'b111, 0, 0, 3'b100, 3'b000, 16'd0);
    tv[35] = mk(3'b000, 0, 0, 3'b000, 3'b000, 16'd0);
    tv[36] = mk(3'b000, 0, 0, 3'b000, 3'b100, 16'd6);

    // Outputs must stay quiet in reset even with requests and controls high.
    drive(3'b111, 1'b1, 1'b1, DA, DB);
    @(negedge clk);
    chk("reset ready", ready, 3'b000);
    chk("reset mul_valid", mul_valid, 1'b0);
    chk("reset mul_lock", mul_lock, 1'b0);
    chk("reset mul_flush", mul_flush, 1'b0);
    chk("reset err", err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b0, DA, DB);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].v, tv[i].lk, tv[i].fl, tv[i].a, tv[i].b);
      @(negedge clk);
      es1 = '0;
      es2 = '0;
      for (int k = 0; k < N; k++) begin
        if (tv[i].rdy[k]) begin
          es1 = tv[i].a[k*8 +: 8];
          es2 = tv[i].b[k*8 +: 8];
        end
      end
      chk($sformatf("v%0d ready", i), ready, tv[i].rdy);
      chk($sformatf("v%0d mul_valid", i), mul_valid, |tv[i].rdy);
      chk($sformatf("v%0d mul_src1", i), mul_src1, es1);
      chk($sformatf("v%0d mul_src2", i), mul_src2, es2);
      chk($sformatf("v%0d mul_lock", i), mul_lock, tv[i].lk);
      chk($sformatf("v%0d mul_flush", i), mul_flush, tv[i].fl);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, tv[i].rsp);
      chk($sformatf("v%0d rsp_data", i), rsp_data, tv[i].dat);
      chk($sformatf("v%0d err", i), err, 1'b0);
      step();
    end

    // Spurious result with an empty tag pipeline sets the sticky error.
    drive(3'b000, 1'b0, 1'b0, DA, DB);
    force_vld = 1'b1;
    @(negedge clk);
    chk("mismatch rsp_valid", rsp_valid, 3'b000);
    chk("mismatch err before edge", err, 1'b0);
    step();
    force_vld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mismatch err sticky", err, 1'b1);
      step();
    end

    // Reset with an operation in flight drops it.
    drive(3'b001, 1'b0, 1'b0, DA, DB);
    @(negedge clk);
    chk("midop grant", ready, 3'b001);
    step();
    rst = 1'b1;
    drive(3'b111, 1'b1, 1'b1, DA, DB);
    #1;
    chk("midop reset ready", ready, 3'b000);
    chk("midop reset mul_valid", mul_valid, 1'b0);
    chk("midop reset mul_lock", mul_lock, 1'b0);
    chk("midop reset rsp_valid", rsp_valid, 3'b000);
    chk("midop reset err", err, 1'b0);
    step();
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b0, DA, DB);
    repeat (3) begin
      @(negedge clk);
      chk("midop no rsp", rsp_valid, 3'b000);
      chk("midop err clear", err, 1'b0);
      step();
    end
    drive(3'b111, 1'b0, 1'b0, DA, DB);
    @(negedge clk);
    chk("post reset first grant", ready, 3'b001);
    step();

`ifdef LAGARTO_FP_MULT_ARB_PRIO_EN
    prio = 3'b100;
    repeat (3) begin
      @(negedge clk);
      chk("prio grant", ready, 3'b100);
      step();
    end
    prio = 3'b000;
    @(negedge clk);
    chk("prio released rotation", ready, 3'b001);
    step();
`endif

    drive(3'b000, 1'b0, 1'b0, DA, DB);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
